mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the core's single external memory port between the instruction-fetch unit (IF) and the load/store unit (LSU), using an OBI-style req/gnt/rvalid handshake. Tracks up to MAX_OUTST in-flight transactions and routes each rvalid back to the source that issued it. Its per-source gnt/rvalid outputs drive the hazard unit's imem_gnt_i/imem_rvalid_i and dmem_gnt_i/dmem_rvalid_i inputs, so arbitration outcomes become pipeline stalls.

Parameters:
MAX_OUTST, 2, max in-flight transactions; legal range 1..4.
STARVE_LIMIT, 4, consecutive IF-denied cycles before IF is forced to priority; only used with the optional feature.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
if_req_i  in  1  IF request
if_addr_i  in  32  IF word address
if_gnt_o  out  1  IF request accepted
if_rvalid_o  out  1  IF read data valid
if_rdata_o  out  32  IF read data
lsu_req_i  in  1  LSU request
lsu_we_i  in  1  LSU write enable
lsu_be_i  in  4  LSU byte enables
lsu_addr_i  in  32  LSU address
lsu_wdata_i  in  32  LSU write data
lsu_gnt_o  out  1  LSU request accepted
lsu_rvalid_o  out  1  LSU response valid; also pulses for write acknowledgements
lsu_rdata_o  out  32  LSU read data
mem_req_o  out  1  bus request
mem_we_o  out  1  bus write enable
mem_be_o  out  4  bus byte enables
mem_addr_o  out  32  bus address
mem_wdata_o  out  32  bus write data
mem_gnt_i  in  1  bus grant
mem_rvalid_i  in  1  bus response valid
mem_rdata_i  in  32  bus read data
busy_o  out  1  outstanding count is nonzero

Behaviour:
- FSM with two states.
  - ARB: owner is selected combinationally each cycle. LSU wins over IF by default.
  - LOCK: entered when mem_req_o=1 and mem_gnt_i=0. Owner and all bus fields are frozen until mem_gnt_i=1, even if the other source requests meanwhile.
  - Grant in ARB or LOCK returns the FSM to ARB in the next cycle.
  - Reset state is ARB.
- Bus request: mem_req_o = owner request AND (count < MAX_OUTST).
  - A response arriving in the same cycle does not free a slot; full means no request that cycle.
- Bus fields when IF owns the port: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
- Grants: if_gnt_o / lsu_gnt_o = mem_gnt_i AND mem_req_o AND (owner==that source). Grants are combinational, with zero-cycle latency.
- Source-ID FIFO:
  - Depth MAX_OUTST, 1 bit per entry (0=IF, 1=LSU).
  - Push on every bus grant; pop on every mem_rvalid_i.
  - Push and pop in the same cycle leave count unchanged.
  - The pointers wrap modulo MAX_OUTST.
- Response routing:
  - if_rvalid_o = mem_rvalid_i AND head==IF; lsu_rvalid_o is defined the same way for LSU.
  - rdata is passed through to both outputs unqualified.
  - Response latency is zero cycles from mem_rvalid_i.
- Spurious response: mem_rvalid_i with count==0 is ignored (no rvalid out, no pop), and count stays 0.
- Reset values: all outputs 0 except mem_be_o=4'hF; count=0; FIFO pointers=0; FSM=ARB.
- Asynchronous reset mid-transaction drops all in-flight IDs; responses arriving after reset are treated as spurious.
- Responses are strictly in order; the bus guarantees in-order return.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN
- Enabled:
  - A saturating counter increments each cycle if_req_i=1 and if_gnt_o=0, and clears on if_gnt_o.
  - When the counter reaches STARVE_LIMIT, IF takes priority over LSU in ARB until its next grant.
- Disabled: fixed LSU priority, no counter logic. IF may starve under continuous LSU traffic.

Test Plan:
- Single IF read: if_req_i=1, addr=0x100, bus grants immediately, rvalid 2 cycles later with rdata=0xDEADBEEF -> if_gnt_o=1 in cycle 0, if_rvalid_o=1 and if_rdata_o=0xDEADBEEF in cycle 2, lsu_rvalid_o=0 throughout, busy_o high for cycles 1-2.
- Simultaneous requests: IF and LSU both request in the same cycle, LSU write we=1 be=4'h3 -> LSU granted first with mem_be_o=4'h3; IF granted the next cycle; responses routed in issue order LSU then IF.
- Lock on stall: LSU requests with mem_gnt_i=0 for 3 cycles, IF requests in cycle 1 -> mem_addr_o and owner stay at LSU through cycle 3, if_gnt_o=0 until the LSU grant, no switching.
- Full FIFO: MAX_OUTST=2, two grants with no responses, third request pending -> mem_req_o=0. After one rvalid, mem_req_o=1 in the following cycle.
- Spurious and reset cases: rvalid with count=0 -> no rvalid outputs, busy_o=0. Reset asserted with 2 outstanding -> busy_o=0 immediately, later rvalids ignored.
- Starvation guard (with MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4): LSU requests every cycle and IF requests continuously -> if_gnt_o=1 by the 5th request cycle. Without the macro, IF is never granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one OBI-style memory port between instruction fetch and the LSU and routes each
// response back to its issuer. Define MEM_ARB_STARVE_GUARD_EN to enable the IF starvation guard.
module mem_port_arbiter #(
  parameter int unsigned MAX_OUTST    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

  localparam logic SrcIf  = 1'b0;
  localparam logic SrcLsu = 1'b1;

  typedef enum logic [0:0] {StArb, StLock} state_e;

  state_e state_q, state_d;

  logic arb_owner, owner, own_req, starving, slot_free;
  logic push, pop, head_id;

  logic        lock_owner_q, lock_owner_d;
  logic        lock_we_q, lock_we_d;
  logic [3:0]  lock_be_q, lock_be_d;
  logic [31:0] lock_addr_q, lock_addr_d;
  logic [31:0] lock_wdata_q, lock_wdata_d;

  logic [MAX_OUTST-1:0] ids_q, ids_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StArb;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArb:   if (mem_req_o && !mem_gnt_i) state_d = StLock;
      StLock:  if (mem_req_o && mem_gnt_i) state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  always_comb begin
    arb_owner = (lsu_req_i && !(starving && if_req_i)) ? SrcLsu : SrcIf;
    if (state_q == StLock) begin
      // A pending request keeps owner and bus fields stable until it is granted.
      owner       = lock_owner_q;
      own_req     = 1'b1;
      mem_we_o    = lock_we_q;
      mem_be_o    = lock_be_q;
      mem_addr_o  = lock_addr_q;
      mem_wdata_o = lock_wdata_q;
    end else if (arb_owner == SrcLsu) begin
      owner       = SrcLsu;
      own_req     = lsu_req_i;
      mem_we_o    = lsu_we_i;
      mem_be_o    = lsu_be_i;
      mem_addr_o  = lsu_addr_i;
      mem_wdata_o = lsu_wdata_i;
    end else begin
      owner       = SrcIf;
      own_req     = if_req_i;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_addr_o  = if_addr_i;
      mem_wdata_o = '0;
    end
    mem_req_o = own_req & slot_free;
    if_gnt_o  = mem_gnt_i & mem_req_o & (owner == SrcIf);
    lsu_gnt_o = mem_gnt_i & mem_req_o & (owner == SrcLsu);
  end

  // ---------------- Lock capture ----------------
  always_comb begin
    lock_owner_d = owner;
    lock_we_d    = mem_we_o;
    lock_be_d    = mem_be_o;
    lock_addr_d  = mem_addr_o;
    lock_wdata_d = mem_wdata_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_owner_q <= SrcIf;
      lock_we_q    <= 1'b0;
      lock_be_q    <= 4'hF;
      lock_addr_q  <= '0;
      lock_wdata_q <= '0;
    end else begin
      lock_owner_q <= lock_owner_d;
      lock_we_q    <= lock_we_d;
      lock_be_q    <= lock_be_d;
      lock_addr_q  <= lock_addr_d;
      lock_wdata_q <= lock_wdata_d;
    end
  end

  // ---------------- Source-ID FIFO ----------------
  assign slot_free = (count_q < CntW'(MAX_OUTST));
  assign push      = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & (count_q != '0);
  assign head_id   = ids_q[rd_ptr_q];

  always_comb begin
    ids_d    = ids_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      ids_d[wr_ptr_q] = owner;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ids_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ids_q    <= ids_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Responses with nothing outstanding never pop, so they produce no rvalid.
  assign if_rvalid_o  = pop & (head_id == SrcIf);
  assign lsu_rvalid_o = pop & (head_id == SrcLsu);
  assign if_rdata_o   = mem_rdata_i;
  assign lsu_rdata_o  = mem_rdata_i;
  assign busy_o       = (count_q != '0);

  // ---------------- Starvation guard ----------------
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned StW = $clog2(STARVE_LIMIT + 1);

  logic [StW-1:0] starve_q, starve_d;

  assign starving = (starve_q == StW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (if_gnt_o) begin
      starve_d = '0;
    end else if (if_req_i && !starving) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign starving            = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, lock/reset/starvation sequences and
// a source-ID scoreboard that predicts where each response must be routed.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        lsu_req_i, lsu_we_i, lsu_gnt_o, lsu_rvalid_o;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_be_i     (lsu_be_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        lsu_req;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        e_if_gnt;
    logic        e_lsu_gnt;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_busy;
  } vec_t;

  int   n_checks = 0;
  int   n_err    = 0;
  logic sb_q[$];  // expected source of each outstanding transaction: 0=IF, 1=LSU
  vec_t tbl[$];

  function automatic vec_t v(input int ir, input logic [31:0] ia, input int lr, input int lw,
                             input logic [3:0] lb, input logic [31:0] la, input logic [31:0] lwd,
                             input int g, input int rv, input logic [31:0] rd,
                             input int eig, input int elg, input int erq, input int ewe,
                             input logic [3:0] ebe, input logic [31:0] ea,
                             input logic [31:0] ewd, input int eb);
    vec_t r;
    r.if_req     = (ir != 0);
    r.if_addr    = ia;
    r.lsu_req    = (lr != 0);
    r.lsu_we     = (lw != 0);
    r.lsu_be     = lb;
    r.lsu_addr   = la;
    r.lsu_wdata  = lwd;
    r.mem_gnt    = (g != 0);
    r.mem_rvalid = (rv != 0);
    r.mem_rdata  = rd;
    r.e_if_gnt   = (eig != 0);
    r.e_lsu_gnt  = (elg != 0);
    r.e_req      = (erq != 0);
    r.e_we       = (ewe != 0);
    r.e_be       = ebe;
    r.e_addr     = ea;
    r.e_wdata    = ewd;
    r.e_busy     = (eb != 0);
    return r;
  endfunction

  // Idle cycle: no requests, optional bus response.
  function automatic vec_t vi(input int rv, input logic [31:0] rd, input int eb);
    return v(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, rv, rd, 0, 0, 0, 0, 4'hF, 32'h0, 32'h0, eb);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives, checks at posedge+3, returns at next posedge+1.
  task automatic apply(input vec_t t, input string tag);
    logic have, src;
    if_req_i     = t.if_req;
    if_addr_i    = t.if_addr;
    lsu_req_i    = t.lsu_req;
    lsu_we_i     = t.lsu_we;
    lsu_be_i     = t.lsu_be;
    lsu_addr_i   = t.lsu_addr;
    lsu_wdata_i  = t.lsu_wdata;
    mem_gnt_i    = t.mem_gnt;
    mem_rvalid_i = t.mem_rvalid;
    mem_rdata_i  = t.mem_rdata;
    #2;
    chk1({tag, ".if_gnt"}, if_gnt_o, t.e_if_gnt);
    chk1({tag, ".lsu_gnt"}, lsu_gnt_o, t.e_lsu_gnt);
    chk1({tag, ".mem_req"}, mem_req_o, t.e_req);
    chk1({tag, ".mem_we"}, mem_we_o, t.e_we);
    chk32({tag, ".mem_be"}, {28'h0, mem_be_o}, {28'h0, t.e_be});
    chk32({tag, ".mem_addr"}, mem_addr_o, t.e_addr);
    chk32({tag, ".mem_wdata"}, mem_wdata_o, t.e_wdata);
    chk1({tag, ".busy"}, busy_o, t.e_busy);
    chk32({tag, ".if_rdata"}, if_rdata_o, t.mem_rdata);
    chk32({tag, ".lsu_rdata"}, lsu_rdata_o, t.mem_rdata);
    have = 1'b0;
    src  = 1'b0;
    if (t.mem_rvalid && sb_q.size() > 0) begin
      src  = sb_q.pop_front();
      have = 1'b1;
    end
    chk1({tag, ".if_rvalid"}, if_rvalid_o, have && !src);
    chk1({tag, ".lsu_rvalid"}, lsu_rvalid_o, have && src);
    if (t.e_if_gnt) sb_q.push_back(1'b0);
    if (t.e_lsu_gnt) sb_q.push_back(1'b1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i     = 1'b0;
    if_addr_i    = '0;
    lsu_req_i    = 1'b0;
    lsu_we_i     = 1'b0;
    lsu_be_i     = '0;
    lsu_addr_i   = '0;
    lsu_wdata_i  = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  initial begin
    vec_t t;
    logic exp_if;
    idle_inputs();
    rst_ni = 1'b0;

    // Basic traffic: single IF read, simultaneous requests, full FIFO, spurious response.
    tbl.push_back(vi(0, 32'h0, 0));
    tbl.push_back(v(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0,
                    1, 0, 1, 0, 4'hF, 32'h100, 32'h0, 0));
    tbl.push_back(vi(0, 32'h0, 1));
    tbl.push_back(vi(1, 32'hDEADBEEF, 1));
    tbl.push_back(vi(0, 32'h0, 0));
    tbl.push_back(v(1, 32'h200, 1, 1, 4'h3, 32'h300, 32'h12345678, 1, 0, 32'h0,
                    0, 1, 1, 1, 4'h3, 32'h300, 32'h12345678, 0));
    tbl.push_back(v(1, 32'h200, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0,
                    1, 0, 1, 0, 4'hF, 32'h200, 32'h0, 1));
    tbl.push_back(v(1, 32'h204, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0,
                    0, 0, 0, 0, 4'hF, 32'h204, 32'h0, 1));
    tbl.push_back(v(1, 32'h204, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'hAAAA0001,
                    0, 0, 0, 0, 4'hF, 32'h204, 32'h0, 1));
    tbl.push_back(v(1, 32'h204, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'hBBBB0002,
                    1, 0, 1, 0, 4'hF, 32'h204, 32'h0, 1));
    tbl.push_back(vi(1, 32'hCCCC0003, 1));
    tbl.push_back(vi(1, 32'hDDDD0004, 0));
    tbl.push_back(vi(0, 32'h0, 0));
    tbl.push_back(v(0, 32'h0, 1, 0, 4'hF, 32'h400, 32'h0, 1, 0, 32'h0,
                    0, 1, 1, 0, 4'hF, 32'h400, 32'h0, 0));
    tbl.push_back(vi(1, 32'h00000055, 1));
    tbl.push_back(vi(0, 32'h0, 0));

    // Reset values, checked after a clock edge with reset held.
    #17;
    chk1("rst.if_gnt", if_gnt_o, 1'b0);
    chk1("rst.if_rvalid", if_rvalid_o, 1'b0);
    chk32("rst.if_rdata", if_rdata_o, 32'h0);
    chk1("rst.lsu_gnt", lsu_gnt_o, 1'b0);
    chk1("rst.lsu_rvalid", lsu_rvalid_o, 1'b0);
    chk32("rst.lsu_rdata", lsu_rdata_o, 32'h0);
    chk1("rst.mem_req", mem_req_o, 1'b0);
    chk1("rst.mem_we", mem_we_o, 1'b0);
    chk32("rst.mem_be", {28'h0, mem_be_o}, 32'hF);
    chk32("rst.mem_addr", mem_addr_o, 32'h0);
    chk32("rst.mem_wdata", mem_wdata_o, 32'h0);
    chk1("rst.busy", busy_o, 1'b0);
    #4 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

    // LSU stalled by the bus while IF requests: LSU keeps the port, fields stay frozen.
    apply(v(0, 32'h0, 1, 1, 4'h1, 32'h500, 32'h11, 0, 0, 32'h0,
            0, 0, 1, 1, 4'h1, 32'h500, 32'h11, 0), "lockA0");
    for (int k = 1; k <= 2; k++) begin
      apply(v(1, 32'h600, 1, 1, 4'h1, 32'h504, 32'h22, 0, 0, 32'h0,
              0, 0, 1, 1, 4'h1, 32'h500, 32'h11, 0), $sformatf("lockA%0d", k));
    end
    apply(v(1, 32'h600, 1, 1, 4'h1, 32'h504, 32'h22, 1, 0, 32'h0,
            0, 1, 1, 1, 4'h1, 32'h500, 32'h11, 0), "lockA3");
    apply(v(1, 32'h600, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0,
            1, 0, 1, 0, 4'hF, 32'h600, 32'h0, 1), "lockA4");
    apply(vi(1, 32'h00000001, 1), "lockA5");
    apply(vi(1, 32'h00000002, 1), "lockA6");
    apply(vi(0, 32'h0, 0), "lockA7");

    // IF stalled first: a higher-priority LSU request must not steal the locked port.
    apply(v(1, 32'h600, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0,
            0, 0, 1, 0, 4'hF, 32'h600, 32'h0, 0), "lockB0");
    apply(v(1, 32'h600, 1, 1, 4'h3, 32'h700, 32'h33, 0, 0, 32'h0,
            0, 0, 1, 0, 4'hF, 32'h600, 32'h0, 0), "lockB1");
    apply(v(1, 32'h600, 1, 1, 4'h3, 32'h700, 32'h33, 1, 0, 32'h0,
            1, 0, 1, 0, 4'hF, 32'h600, 32'h0, 0), "lockB2");
    apply(v(0, 32'h0, 1, 1, 4'h3, 32'h700, 32'h33, 1, 0, 32'h0,
            0, 1, 1, 1, 4'h3, 32'h700, 32'h33, 1), "lockB3");
    apply(vi(1, 32'h00000003, 1), "lockB4");
    apply(vi(1, 32'h00000004, 1), "lockB5");
    apply(vi(0, 32'h0, 0), "lockB6");

    // Reset with two transactions in flight; later responses are spurious.
    apply(v(1, 32'h800, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0,
            1, 0, 1, 0, 4'hF, 32'h800, 32'h0, 0), "rstmid0");
    apply(v(0, 32'h0, 1, 0, 4'hF, 32'h900, 32'h0, 1, 0, 32'h0,
            0, 1, 1, 0, 4'hF, 32'h900, 32'h0, 1), "rstmid1");
    idle_inputs();
    #1;
    chk1("rstmid.busy_before", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk1("rstmid.busy_async", busy_o, 1'b0);
    chk1("rstmid.mem_req", mem_req_o, 1'b0);
    sb_q.delete();
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    apply(vi(1, 32'hEEEE0001, 0), "rstmid2");
    apply(vi(1, 32'hEEEE0002, 0), "rstmid3");
    apply(vi(0, 32'h0, 0), "rstmid4");

    // Continuous LSU and IF traffic; one response returns each cycle so the FIFO never fills.
    for (int k = 0; k < 10; k++) begin
      exp_if = Guard && ((k % 5) == 4);
      t = v(1, 32'hA000, 1, 0, 4'hF, 32'hB000, 32'h0, 1, (k > 0) ? 1 : 0, 32'h7000 + 32'(k),
            exp_if ? 1 : 0, exp_if ? 0 : 1, 1, 0, 4'hF, exp_if ? 32'hA000 : 32'hB000, 32'h0,
            (k > 0) ? 1 : 0);
      apply(t, $sformatf("starve%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
